fir_avg_fifo: RTL and testbench
===============================

# fir_avg_fifo

Output stage directly downstream of the 4-tap FIR summer: consumes its (W+2)-bit tap sum, converts it to a rounded W-bit moving average (sum/4), discards the pipeline warm-up samples after reset, and buffers results in a small FIFO with a valid/ready handshake toward the consumer. Overflow is reported, never stalled upstream: the FIR has no back-pressure input.

## Interface
- W, default 16: sample width; input sum is W+2 bits, output average is W bits
- DEPTH, default 4: FIFO entries; power of two, ≥2
- WARMUP, default 3: number of valid input samples discarded after reset; 0 disables
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- in_data  input  W+2  unsigned tap sum from FIR stage
- in_valid  input  1  in_data carries a new sample this cycle
- out_data  output  W  head-of-FIFO average; 0 when FIFO empty
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head this cycle
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- warm  output  1  warm-up complete; high once WARMUP samples discarded
- overflow  output  1  sticky; set when an accepted sample is dropped because FIFO full

## Operation
- Average: avg = (in_data + 2) >> 2, computed at W+3 bits, low W bits kept; round-half-up. Max input 4·(2^W−1) gives 2^W−1, so no saturation is needed.
- Warm-up counter: 0..WARMUP, saturating.
  - Each in_valid while counter < WARMUP increments it and discards the sample.
  - warm = (counter == WARMUP).
- Accept: in_valid && warm.
- Pop: out_valid && out_ready.
- Push: accept && (count < DEPTH || pop).
- Drop: accept && count == DEPTH && !pop. The sample is lost and overflow is set. overflow holds until reset.
- FIFO: register array mem[DEPTH], wr_ptr/rd_ptr wrap modulo DEPTH.
  - Push writes mem[wr_ptr] and increments wr_ptr.
  - Pop increments rd_ptr.
  - count += push − pop.
- Simultaneous push and pop:
  - When full: both occur, count stays DEPTH, no drop.
  - When empty: no pop (out_valid low), push only.
- out_data = mem[rd_ptr] when count != 0, else 0 (combinational from registers).
- Order preserved. No duplication. No sample reaches output before warm.

## Timing
- Reset values: out_data 0, out_valid 0, count 0, warm 0 (1 if WARMUP=0), overflow 0, ptrs 0, warm-up counter 0.
- Reset asserted mid-operation flushes the FIFO, restarts warm-up, and clears overflow at the next edge. Inputs are ignored while reset is high.
- Latency: a sample accepted at edge k appears on out_data/out_valid in the cycle after edge k, if the FIFO was empty. Otherwise it appears after all earlier entries are popped.
- Pop takes effect at the edge where out_valid && out_ready. The next entry (or 0/invalid) is visible the following cycle.
- warm rises in the cycle after the edge that consumes the WARMUP-th valid sample. The sample on that edge is discarded, not pushed.
- Throughput: one push and one pop per cycle sustained.
- in_valid low: no counter or FIFO change except a pop.

## Test plan
- Warm-up, defaults: reset, then in_valid=1 with in_data 4, 8, 12, 16 on four consecutive cycles, out_ready=1 -> first three samples discarded, warm rises after third; out_data=4 with out_valid=1 for exactly one cycle; count never exceeds 1.
- Rounding: after warm-up, in_data = 1, 2, 5, 262140 -> out_data 0, 1, 1, 65535 in order.
- Full/overflow: out_ready=0, after warm-up push 5 samples 40, 80, 120, 160, 200 -> count=4, overflow=1 after fifth edge; then out_ready=1 -> 10, 20, 30, 40 emitted, 50 absent, count returns to 0, overflow stays 1.
- Push+pop at full: FIFO full (count=4), in_valid=1 and out_ready=1 same cycle -> count stays 4, overflow stays 0, head advances, new sample enters at tail.
- Back-pressure and wrap: random out_ready at about 50% with in_valid at about 25% for 1000 cycles -> output sequence equals the reference-model average sequence, with pointers wrapping many times and no drops.
- Mid-operation reset: FIFO holding 3 entries with overflow=1, pulse reset one cycle -> next cycle count=0, out_valid=0, out_data=0, overflow=0, warm=0; the next 3 valid samples are discarded again.

Source files
------------

// File: rtl/fir_avg_fifo_if.sv
// Stream bundle between the FIR summer, the averaging FIFO and its consumer.
// The slave modport is the FIFO side; the master modport drives it.
interface fir_avg_fifo_if #(
    parameter int W     = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W+1:0]  in_data;
    logic          in_valid;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          warm;
    logic          overflow;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output count,
        output warm,
        output overflow
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  count,
        input  warm,
        input  overflow
    );
endinterface

// File: rtl/fir_avg_fifo.sv
// Rounded sum/4 of the FIR tap sum, warm-up discard, and a small output FIFO.
// Upstream cannot stall: samples arriving at a full FIFO are dropped and flagged.
module fir_avg_fifo #(
    parameter int W      = 16,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 3
) (
    input  logic             clk,
    input  logic             reset,
    fir_avg_fifo_if.slave    bus
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    logic [W+2:0]   sum_rnd;
    logic [W-1:0]   avg;

    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   mem_q [DEPTH];

    logic           warm;
    logic           full;
    logic           empty;
    logic           accept;
    logic           pop;
    logic           push;
    logic           drop;

    // One extra bit of headroom keeps the +2 rounding carry.
    assign sum_rnd = {1'b0, bus.in_data} + (W + 3)'(2);
    assign avg     = W'(sum_rnd >> 2);

    assign warm   = (wcnt_q == WCW'(WARMUP));
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = bus.in_valid && warm;
    assign pop    = !empty && bus.out_ready;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    always_comb begin
        wcnt_d   = wcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (bus.in_valid && !warm) begin
            wcnt_d = wcnt_q + WCW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= avg;
        end
    end

    assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.out_valid = !empty;
    assign bus.count     = count_q;
    assign bus.warm      = warm;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fir_avg_fifo.sv
// Directed vector table plus hand sequences and a randomized scoreboard run
// for the averaging output FIFO.
module tb_fir_avg_fifo;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fir_avg_fifo_if #(.W(16), .DEPTH(4)) bus ();

    fir_avg_fifo #(.W(16), .DEPTH(4), .WARMUP(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int iv;
        int d;
        int rdy;
        int ev;
        int ed;
        int ec;
        int ew;
        int eo;
    } vec_t;

    vec_t tbl[18];
    int   errors = 0;
    int   checks = 0;
    int   q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int iv, input int d, input int rdy);
        bus.in_valid  = (iv != 0);
        bus.in_data   = 18'(d);
        bus.out_ready = (rdy != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int v, input int d,
                             input int c, input int w, input int o);
        chk({tag, ".valid"}, int'(bus.out_valid), v);
        chk({tag, ".data"}, int'(bus.out_data), d);
        chk({tag, ".count"}, int'(bus.count), c);
        chk({tag, ".warm"}, int'(bus.warm), w);
        chk({tag, ".ovf"}, int'(bus.overflow), o);
    endtask

    initial begin
        // iv, d, rdy | valid, data, count, warm, ovf after the edge
        tbl[0]  = '{1, 4, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 8, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 12, 1, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 16, 1, 1, 4, 1, 1, 0};
        tbl[4]  = '{1, 1, 1, 1, 0, 1, 1, 0};
        tbl[5]  = '{1, 2, 1, 1, 1, 1, 1, 0};
        tbl[6]  = '{1, 5, 1, 1, 1, 1, 1, 0};
        tbl[7]  = '{1, 262140, 1, 1, 65535, 1, 1, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
        tbl[9]  = '{1, 40, 0, 1, 10, 1, 1, 0};
        tbl[10] = '{1, 80, 0, 1, 10, 2, 1, 0};
        tbl[11] = '{1, 120, 0, 1, 10, 3, 1, 0};
        tbl[12] = '{1, 160, 0, 1, 10, 4, 1, 0};
        tbl[13] = '{1, 200, 0, 1, 10, 4, 1, 1};
        tbl[14] = '{0, 0, 1, 1, 20, 3, 1, 1};
        tbl[15] = '{0, 0, 1, 1, 30, 2, 1, 1};
        tbl[16] = '{0, 0, 1, 1, 40, 1, 1, 1};
        tbl[17] = '{0, 0, 1, 0, 0, 0, 1, 1};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].iv, tbl[i].d, tbl[i].rdy);
            chk_state($sformatf("v%0d", i), tbl[i].ev, tbl[i].ed,
                      tbl[i].ec, tbl[i].ew, tbl[i].eo);
        end

        // Mid-operation reset with 3 entries and overflow set
        cyc(1, 4, 0);
        cyc(1, 8, 0);
        cyc(1, 12, 0);
        chk_state("pre_rst", 1, 1, 3, 1, 1);
        reset = 1'b1;
        cyc(1, 16, 1);
        reset = 1'b0;
        chk_state("mid_rst", 0, 0, 0, 0, 0);
        cyc(1, 4, 1);
        chk_state("rewarm0", 0, 0, 0, 0, 0);
        cyc(1, 8, 1);
        chk_state("rewarm1", 0, 0, 0, 0, 0);
        cyc(1, 12, 1);
        chk_state("rewarm2", 0, 0, 0, 1, 0);
        cyc(1, 40, 0);
        chk_state("rewarm3", 1, 10, 1, 1, 0);

        // Push and pop together while full
        cyc(1, 8, 0);
        cyc(1, 12, 0);
        cyc(1, 16, 0);
        chk_state("full", 1, 10, 4, 1, 0);
        cyc(1, 20, 1);
        chk_state("fullpp", 1, 2, 4, 1, 0);
        cyc(0, 0, 1);
        chk_state("drain0", 1, 3, 3, 1, 0);
        cyc(0, 0, 1);
        chk_state("drain1", 1, 4, 2, 1, 0);
        cyc(0, 0, 1);
        chk_state("drain2", 1, 5, 1, 1, 0);
        cyc(0, 0, 1);
        chk_state("drain3", 0, 0, 0, 1, 0);

        // Random back-pressure against a queue model, never offering a drop
        for (int n = 0; n < 1000; n++) begin
            int rdy;
            int iv;
            int d;
            chk("rnd.valid", int'(bus.out_valid), (q.size() != 0) ? 1 : 0);
            chk("rnd.data", int'(bus.out_data), (q.size() != 0) ? q[0] : 0);
            chk("rnd.count", int'(bus.count), q.size());
            rdy = int'($urandom_range(0, 1));
            iv  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (q.size() == 4 && rdy == 0) iv = 0;
            d = int'($urandom_range(0, 262140));
            cyc(iv, d, rdy);
            if (rdy != 0 && q.size() != 0) void'(q.pop_front());
            if (iv != 0) q.push_back((d + 2) / 4);
        end
        chk("rnd.ovf", int'(bus.overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
